adc_capture_sequencer: RTL and testbench
========================================

ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports address (in, 2), chipselect (in, 1), write_n (in, 1), writedata (in, 32) and readdata (out, 32): Avalon-MM slave with zero-wait writes and combinational readdata.
REQ-004 SHALL have port sample_num, input, 16: capture length, driven by the sampleNum PIO.
REQ-005 SHALL have port trigger, input, 1: hardware trigger, synchronous to clk.
REQ-006 SHALL have ports adc_data (in, 14) and adc_valid (in, 1): the ADC sample stream.
REQ-007 SHALL have ports out_data (out, 16), out_valid (out, 1), out_ready (in, 1), out_sop (out, 1) and out_eop (out, 1): the capture stream.
REQ-008 SHALL have port irq, output, 1: level interrupt.

Function
REQ-009 Register map SHALL be:
- addr0 CONTROL (W): bit0 ARM, bit1 ABORT, bit2 SW_TRIG, bit3 AUTO_REARM (stored), bit4 IRQ_EN (stored).
- addr1 STATUS: bit0 armed, bit1 busy, bit2 done (sticky, write-1-clear), bit3 overflow (sticky, write-1-clear).
- addr2 CAPTURE_COUNT (RO): completed captures, 16 bit, wraps to 0.
- addr3 LENGTH (RO): latched length.
REQ-010 Reads SHALL zero-extend to 32 bits; CONTROL SHALL read back bits 4:3 only, other bits 0.
REQ-011 FSM states SHALL be IDLE, ARMED, CAPTURE, DRAIN.
REQ-012 IDLE->ARMED SHALL occur on a CONTROL write with ARM=1 and ABORT=0; on that clock LENGTH latches sample_num, with 0 latched as 1.
REQ-013 A trigger event SHALL be the rising edge of trigger (registered: trigger & ~trigger_q) or a CONTROL write with SW_TRIG=1.
REQ-014 ARMED->CAPTURE SHALL occur on the clock edge at which a trigger event is present; trigger events in any other state SHALL be ignored.
REQ-015 In CAPTURE, each adc_valid=1 cycle SHALL be accepted if out_valid=0 or out_ready=1. On acceptance, the next clock SHALL give out_data={2'b00,adc_data}, out_valid=1, out_sop=(first sample), out_eop=(sample index==LENGTH-1), and the sample counter SHALL increment.
REQ-016 An adc_valid cycle in CAPTURE that is not accepted (out_valid=1 and out_ready=0) SHALL be dropped, SHALL NOT be counted, and SHALL set overflow.
REQ-017 out_valid SHALL clear the clock after out_ready=1 when no new sample is loaded; out_data/sop/eop SHALL hold while out_valid=1 and out_ready=0.
REQ-018 Acceptance of the last sample SHALL move CAPTURE->DRAIN.
REQ-019 In DRAIN, the eop beat handshake (out_valid & out_ready) SHALL:
- set done;
- increment CAPTURE_COUNT;
- go to ARMED if AUTO_REARM=1 (LENGTH re-latched from sample_num), else to IDLE.
REQ-020 ABORT=1 SHALL force IDLE on the next clock from any state and clear out_valid/out_sop/out_eop and the sample counter; done and CAPTURE_COUNT SHALL be unchanged; ABORT SHALL win over simultaneous ARM/SW_TRIG.
REQ-021 ARM in any state other than IDLE SHALL be ignored.
REQ-022 A write-1-clear of done coinciding with a done set SHALL leave done=1.
REQ-023 Status SHALL be: busy=1 in CAPTURE or DRAIN; armed=1 in ARMED.
REQ-024 irq SHALL equal done & IRQ_EN.

Reset
REQ-025 reset_n=0 SHALL asynchronously force:
- state IDLE; all CONTROL bits 0; done=0; overflow=0;
- CAPTURE_COUNT=0; LENGTH=15; sample counter=0; trigger_q=0;
- out_valid=0, out_sop=0, out_eop=0, out_data=0, irq=0.
REQ-026 Reset asserted mid-capture SHALL discard the capture with no done set.

Verification
REQ-027 sample_num=4, ARM, trigger rising, adc_valid continuous, out_ready=1 -> 4 beats, sop on beat 0, eop on beat 3, done=1, CAPTURE_COUNT=1, state IDLE.
REQ-028 sample_num=0, ARM, SW_TRIG -> exactly one beat with sop=eop=1; LENGTH reads 1.
REQ-029 sample_num=8, out_ready held 0 for 3 adc_valid cycles mid-capture -> overflow=1, 2 samples dropped, still 8 beats delivered, eop on the 8th.
REQ-030 ABORT during CAPTURE after 2 of 8 beats -> IDLE next clock, out_valid=0, done=0, CAPTURE_COUNT unchanged.
REQ-031 AUTO_REARM=1, IRQ_EN=1, two triggers -> CAPTURE_COUNT=2, irq=1 until done is cleared by W1C, armed=1 after each capture.
REQ-032 reset_n pulsed low mid-capture -> all outputs per REQ-025 immediately, LENGTH reads 15.

Source files
------------

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: armed, triggered capture of an ADC sample stream onto a ready/valid packet stream, with an Avalon-MM control and status block.
module adc_capture_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sample_num,
  input  logic        trigger,
  input  logic [13:0] adc_data,
  input  logic        adc_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        irq
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DRAIN = 2'd3;
  logic [1:0]  state, next_state;
  logic        auto_rearm, irq_en, done, overflow, trigger_q;
  logic [15:0] capture_count, length, sample_cnt, next_length;
  logic        ctrl_wr, stat_wr, abort, arm, trig_evt, handshake, accept, drop, last, finish;
  logic        unused_wd;
  assign unused_wd   = ^writedata[31:5];
  assign ctrl_wr     = chipselect & ~write_n & (address == 2'd0);
  assign stat_wr     = chipselect & ~write_n & (address == 2'd1);
  assign abort       = ctrl_wr & writedata[1];
  assign arm         = ctrl_wr & writedata[0] & ~abort;
  assign trig_evt    = (trigger & ~trigger_q) | (ctrl_wr & writedata[2]);
  assign handshake   = out_valid & out_ready;
  assign accept      = (state == CAPTURE) & adc_valid & (~out_valid | out_ready);
  assign drop        = (state == CAPTURE) & adc_valid & out_valid & ~out_ready;
  assign last        = sample_cnt == length - 16'd1;
  assign finish      = (state == DRAIN) & handshake & ~abort;
  assign next_length = (sample_num == 16'd0) ? 16'd1 : sample_num;
  assign irq         = done & irq_en;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = arm ? ARMED : IDLE;
      ARMED:   next_state = trig_evt ? CAPTURE : ARMED;
      CAPTURE: next_state = (accept & last) ? DRAIN : CAPTURE;
      default: next_state = finish ? (auto_rearm ? ARMED : IDLE) : DRAIN;
    endcase
    if (abort) next_state = IDLE;
  end
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {27'd0, irq_en, auto_rearm, 3'd0};
      2'd1:    readdata = {28'd0, overflow, done, (state == CAPTURE) | (state == DRAIN), state == ARMED};
      2'd2:    readdata = {16'd0, capture_count};
      default: readdata = {16'd0, length};
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      auto_rearm    <= 1'b0;
      irq_en        <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      trigger_q     <= 1'b0;
      capture_count <= 16'd0;
      length        <= 16'd15;
      sample_cnt    <= 16'd0;
    end else begin
      state     <= next_state;
      trigger_q <= trigger;
      if (ctrl_wr) {irq_en, auto_rearm} <= writedata[4:3];
      // a done set in the same cycle as its W1C must survive
      if (finish) done <= 1'b1;
      else if (stat_wr & writedata[2]) done <= 1'b0;
      if (drop) overflow <= 1'b1;
      else if (stat_wr & writedata[3]) overflow <= 1'b0;
      if (finish) capture_count <= capture_count + 16'd1;
      if (((state == IDLE) & arm) | (finish & auto_rearm)) length <= next_length;
      if (abort | ((state == ARMED) & trig_evt)) sample_cnt <= 16'd0;
      else if (accept) sample_cnt <= sample_cnt + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= 16'd0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (accept) begin
      out_data  <= {2'b00, adc_data};
      out_valid <= 1'b1;
      out_sop   <= sample_cnt == 16'd0;
      out_eop   <= last;
    end else if (handshake) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer: directed scenarios checked against a per-cycle behavioural model plus hand-computed expectations.
module tb_adc_capture_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] sample_num = 16'd0;
  logic        trigger = 1'b0;
  logic [13:0] adc_data = 14'd0;
  logic        adc_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sop;
  logic        out_eop;
  logic        irq;
  int checks = 0, failures = 0;
  int seq = 0;
  int beats = 0, sop_idx = -1, eop_idx = -1, n_eop = 0;
  adc_capture_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .sample_num(sample_num), .trigger(trigger), .adc_data(adc_data),
    .adc_valid(adc_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // behavioural model: m_st 0 idle, 1 armed, 2 capturing, 3 draining
  int          m_st = 0, m_drops = 0;
  logic [15:0] m_len = 16'd15, m_n = 16'd0, m_cnt = 16'd0, m_data = 16'd0;
  bit          m_done, m_ovf, m_ar, m_ie, m_tq, m_ov, m_sop, m_eop;
  bit          cw, sw, ab, trg, hs, fin, dr;
  int          s;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st = 0; m_len = 16'd15; m_n = 16'd0; m_cnt = 16'd0; m_data = 16'd0;
      m_done = 0; m_ovf = 0; m_ar = 0; m_ie = 0; m_tq = 0; m_ov = 0; m_sop = 0; m_eop = 0;
    end else begin
      cw  = chipselect && !write_n && address == 2'd0;
      sw  = chipselect && !write_n && address == 2'd1;
      ab  = cw && writedata[1];
      trg = (trigger && !m_tq) || (cw && writedata[2]);
      hs  = m_ov && out_ready;
      s   = m_st;
      dr  = s == 2 && adc_valid && m_ov && !out_ready;
      fin = !ab && s == 3 && hs;
      if (dr) begin m_ovf = 1; m_drops++; end
      else if (sw && writedata[3]) m_ovf = 0;
      if (fin) begin m_done = 1; m_cnt++; end
      else if (sw && writedata[2]) m_done = 0;
      m_tq = trigger;
      if (ab) begin
        m_st = 0; m_ov = 0; m_sop = 0; m_eop = 0; m_n = 16'd0;
      end else begin
        if (s == 2 && adc_valid && !dr) begin
          m_data = {2'b00, adc_data}; m_ov = 1;
          m_sop = m_n == 0; m_eop = 32'(m_n) + 1 == 32'(m_len); m_n++;
          if (m_eop) m_st = 3;
        end else if (hs) begin
          m_ov = 0; m_sop = 0; m_eop = 0;
        end
        if (s == 0 && cw && writedata[0]) begin m_st = 1; m_len = sample_num == 0 ? 16'd1 : sample_num; end
        if (s == 1 && trg) begin m_st = 2; m_n = 16'd0; end
        if (fin) begin
          m_st = m_ar ? 1 : 0;
          if (m_ar) m_len = sample_num == 0 ? 16'd1 : sample_num;
        end
      end
      if (cw) begin m_ar = writedata[3]; m_ie = writedata[4]; end
    end
  end
  always @(posedge clk) begin
    #2;
    if (reset_n) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("irq", 32'(irq), 32'(m_done && m_ie));
      if (m_ov) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_sop", 32'(out_sop), 32'(m_sop));
        chk("out_eop", 32'(out_eop), 32'(m_eop));
      end
    end
  end
  always @(posedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (out_sop) sop_idx = beats;
      if (out_eop) begin eop_idx = beats; n_eop++; end
      beats++;
    end
  end
  task automatic clr();
    beats = 0; sop_idx = -1; eop_idx = -1; n_eop = 0;
  endtask
  task automatic step(input logic av, input logic rdy);
    adc_valid = av; out_ready = rdy;
    seq = seq + 113; adc_data = 14'(seq);
    @(negedge clk);
  endtask
  task automatic cycles(input int n);
    repeat (n) step(adc_valid, out_ready);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    address = a;
    #1 chk(n, readdata, e);
  endtask
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    logic [5:0] av_t, rdy_t;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, 32'd0, "reset_control");
    rd(2'd1, 32'd0, "reset_status");
    rd(2'd2, 32'd0, "reset_count");
    rd(2'd3, 32'd15, "reset_length");
    // basic 4-beat capture; trigger in IDLE and re-ARM while ARMED both ignored
    trigger = 1'b1; cycles(1); trigger = 1'b0; cycles(1);
    rd(2'd1, 32'd0, "idle_trigger_ignored");
    sample_num = 16'd4; wr(2'd0, 32'h1);
    rd(2'd1, 32'd1, "armed");
    sample_num = 16'd9; wr(2'd0, 32'h1);
    rd(2'd3, 32'd4, "rearm_ignored_length");
    clr(); adc_valid = 1'b1; out_ready = 1'b1; trigger = 1'b1;
    cycles(12); trigger = 1'b0;
    chk("t1_beats", 32'(beats), 32'd4);
    chk("t1_sop_idx", 32'(sop_idx), 32'd0);
    chk("t1_eop_idx", 32'(eop_idx), 32'd3);
    rd(2'd1, 32'd4, "t1_status");
    rd(2'd2, 32'd1, "t1_count");
    // length 0 -> single beat; done W1C in the same cycle done sets
    adc_valid = 1'b0; wr(2'd1, 32'h4);
    rd(2'd1, 32'd0, "done_cleared");
    sample_num = 16'd0; wr(2'd0, 32'h1);
    rd(2'd3, 32'd1, "len0_latched_1");
    clr(); adc_valid = 1'b1; out_ready = 1'b1;
    wr(2'd0, 32'h4);
    cycles(1);
    wr(2'd1, 32'h4);
    rd(2'd1, 32'd4, "w1c_vs_set_done");
    cycles(4);
    chk("t2_beats", 32'(beats), 32'd1);
    chk("t2_eops", 32'(n_eop), 32'd1);
    chk("t2_sop_idx", 32'(sop_idx), 32'd0);
    rd(2'd2, 32'd2, "t2_count");
    // backpressure: two drops, still eight beats
    adc_valid = 1'b0; wr(2'd1, 32'hc);
    sample_num = 16'd8; wr(2'd0, 32'h1);
    clr(); m_drops = 0; out_ready = 1'b1; wr(2'd0, 32'h4);
    av_t = 6'b111011; rdy_t = 6'b000111;
    for (int i = 0; i < 6; i++) step(av_t[i], rdy_t[i]);
    adc_valid = 1'b1; out_ready = 1'b1; cycles(10);
    chk("t3_beats", 32'(beats), 32'd8);
    chk("t3_eop_idx", 32'(eop_idx), 32'd7);
    chk("t3_model_drops", 32'(m_drops), 32'd2);
    rd(2'd1, 32'hc, "t3_status_ovf");
    rd(2'd2, 32'd3, "t3_count");
    // abort mid-capture
    adc_valid = 1'b0; wr(2'd1, 32'hc);
    wr(2'd0, 32'h1);
    clr(); adc_valid = 1'b1; out_ready = 1'b1; wr(2'd0, 32'h4);
    for (int i = 0; i < 20 && beats < 2; i++) cycles(1);
    chk("t4_reached_2_beats", 32'(beats >= 2), 32'd1);
    wr(2'd0, 32'h2);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    rd(2'd1, 32'd0, "t4_status");
    rd(2'd2, 32'd3, "t4_count");
    adc_valid = 1'b0; cycles(2);
    // auto re-arm with interrupt
    sample_num = 16'd2; wr(2'd0, 32'h19);
    rd(2'd0, 32'h18, "t5_control");
    clr(); adc_valid = 1'b1; out_ready = 1'b1; trigger = 1'b1; cycles(8);
    rd(2'd1, 32'd5, "t5_status_1");
    rd(2'd2, 32'd4, "t5_count_1");
    chk("t5_irq_1", 32'(irq), 32'd1);
    trigger = 1'b0; cycles(1); trigger = 1'b1; cycles(8); trigger = 1'b0;
    rd(2'd1, 32'd5, "t5_status_2");
    rd(2'd2, 32'd5, "t5_count_2");
    chk("t5_beats", 32'(beats), 32'd4);
    chk("t5_eops", 32'(n_eop), 32'd2);
    wr(2'd1, 32'h4);
    rd(2'd1, 32'd1, "t5_status_cleared");
    chk("t5_irq_cleared", 32'(irq), 32'd0);
    // asynchronous reset mid-capture
    adc_valid = 1'b0; wr(2'd0, 32'h2);
    sample_num = 16'd8; wr(2'd0, 32'h1);
    adc_valid = 1'b1; out_ready = 1'b1; wr(2'd0, 32'h4);
    cycles(3);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_sop", 32'(out_sop), 32'd0);
    chk("t6_out_eop", 32'(out_eop), 32'd0);
    chk("t6_out_data", 32'(out_data), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    rd(2'd3, 32'd15, "t6_length");
    rd(2'd1, 32'd0, "t6_status");
    rd(2'd2, 32'd0, "t6_count");
    @(negedge clk);
    reset_n = 1'b1; adc_valid = 1'b0; cycles(2);
    rd(2'd1, 32'd0, "t6_status_after");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
